// File: rtl/uart_tx_fifo_if.sv
// Byte-push / uart_tx handshake bundle between the bus side and uart_tx_fifo.
// master drives writes and the busy line; slave is the FIFO itself.
interface uart_tx_fifo_if #(
    parameter int DEPTH = 16
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic          wr_en;
    logic [7:0]    wr_data;
    logic          full;
    logic          empty;
    logic [CW-1:0] count;
    logic          overflow;
    logic          tx_busy;
    logic          tx_en;
    logic [7:0]    tx_data;

    modport master (
        output wr_en, wr_data, tx_busy,
        input  full, empty, count, overflow, tx_en, tx_data
    );

    modport slave (
        input  wr_en, wr_data, tx_busy,
        output full, empty, count, overflow, tx_en, tx_data
    );
endinterface

// File: rtl/uart_tx_fifo.sv
// Byte FIFO plus issue sequencer feeding uart_tx one byte per frame.
// A byte is popped only on IDLE->ISSUE, so count excludes the byte in flight.
module uart_tx_fifo #(
    parameter int DEPTH = 16
) (
    input  logic          clk,
    input  logic          rst,
    uart_tx_fifo_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("uart_tx_fifo: DEPTH must be a power of two >= 2");
    end

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_ACK,
        WAIT_DONE
    } state_e;

    state_e        state_q, state_d;
    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          full_q, full_d;
    logic          empty_q, empty_d;
    logic          overflow_q, overflow_d;
    logic          tx_en_q, tx_en_d;
    logic [7:0]    tx_data_q, tx_data_d;
    logic          push;
    logic          pop;

    // Full is the registered flag, so a push into a full FIFO drops even on a pop edge.
    assign push = bus.wr_en && !full_q;

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= bus.wr_data;
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        full_d     = (count_d == FULL_CNT);
        empty_d    = (count_d == '0);
        overflow_d = bus.wr_en && full_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            full_q     <= full_d;
            empty_q    <= empty_d;
            overflow_q <= overflow_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            tx_en_q   <= 1'b0;
            tx_data_q <= 8'h00;
        end else begin
            state_q   <= state_d;
            tx_en_q   <= tx_en_d;
            tx_data_q <= tx_data_d;
        end
    end

    // WAIT_ACK has no timeout: uart_tx raises busy on the edge after it samples en.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:      if (!empty_q && !bus.tx_busy) state_d = ISSUE;
            ISSUE:     state_d = WAIT_ACK;
            WAIT_ACK:  if (bus.tx_busy) state_d = WAIT_DONE;
            WAIT_DONE: if (!bus.tx_busy) state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    always_comb begin
        pop       = (state_q == IDLE) && !empty_q && !bus.tx_busy;
        tx_en_d   = pop;
        tx_data_d = pop ? mem_q[rd_ptr_q] : tx_data_q;
    end

    assign bus.full     = full_q;
    assign bus.empty    = empty_q;
    assign bus.count    = count_q;
    assign bus.overflow = overflow_q;
    assign bus.tx_en    = tx_en_q;
    assign bus.tx_data  = tx_data_q;
endmodule
